// File: rtl/motion_detector_pkg.sv
// rtl/motion_detector_pkg.sv - shared types, widths and helpers for motion_detector
package motion_pkg;

  localparam int DATA_W = 12;
  localparam int MAG_W  = DATA_W + 2;

  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,
    ST_STILL  = 2'd1,
    ST_MOVING = 2'd2
  } state_t;

  // Difference is taken one bit wider so that -2048 - 2047 cannot wrap.
  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] d;
    d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    if (d[DATA_W]) begin
      d = -d;
    end
    return d[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/motion_detector_if.sv
// rtl/motion_detector_if.sv - sample stream in, motion status out
interface motion_detector_if;
  import motion_pkg::*;

  logic              sample_valid;
  logic [DATA_W-1:0] sample_x;
  logic [DATA_W-1:0] sample_y;
  logic [DATA_W-1:0] sample_z;
  logic              clear_count;
  logic              moving;
  logic [15:0]       value;
  logic [MAG_W-1:0]  mag;
  logic              mag_valid;

  modport master (
    output sample_valid, sample_x, sample_y, sample_z, clear_count,
    input  moving, value, mag, mag_valid
  );

  modport slave (
    input  sample_valid, sample_x, sample_y, sample_z, clear_count,
    output moving, value, mag, mag_valid
  );

endinterface

// File: rtl/motion_detector_axis_delta.sv
// rtl/motion_detector_axis_delta.sv - per-axis previous-sample register and |cur-prev|
module axis_delta
  import motion_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] cur,
  output logic [DATA_W-1:0] absd
);

  logic [DATA_W-1:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      absd   <= '0;
    end else if (load) begin
      prev_q <= cur;
      absd   <= abs_diff(cur, prev_q);
    end
  end

endmodule

// File: rtl/motion_detector.sv
// rtl/motion_detector.sv - L1 sample-to-sample motion detector with hold timer and event count
module motion_detector
  import motion_pkg::*;
#(
  parameter int THRESH      = 64,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input logic              clk,
  input logic              rst,
  motion_detector_if.slave bus
);

  localparam int                HOLD_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [MAG_W-1:0]  THRESH_M    = MAG_W'(THRESH);

  logic [DATA_W-1:0] abs_x, abs_y, abs_z;
  logic              v1_q;
  logic [MAG_W-1:0]  sum;
  logic [MAG_W-1:0]  mag_q;
  logic              mag_valid_q;
  logic              hit_q;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       value_q, value_d;

  axis_delta u_dx (.clk(clk), .rst(rst), .load(bus.sample_valid), .cur(bus.sample_x), .absd(abs_x));
  axis_delta u_dy (.clk(clk), .rst(rst), .load(bus.sample_valid), .cur(bus.sample_y), .absd(abs_y));
  axis_delta u_dz (.clk(clk), .rst(rst), .load(bus.sample_valid), .cur(bus.sample_z), .absd(abs_z));

  // The priming sample still loads prev, but its deltas are against zero and must not count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= bus.sample_valid && (state_q != ST_PRIME);
    end
  end

  assign sum = MAG_W'(abs_x) + MAG_W'(abs_y) + MAG_W'(abs_z);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q       <= '0;
      mag_valid_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      mag_valid_q <= v1_q;
      hit_q       <= v1_q && (sum > THRESH_M);
      if (v1_q) begin
        mag_q <= sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PRIME;
      hold_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      value_q <= value_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    value_d = value_q;
    case (state_q)
      ST_PRIME: begin
        if (bus.sample_valid) begin
          state_d = ST_STILL;
        end
      end
      ST_STILL: begin
        if (hit_q) begin
          state_d = ST_MOVING;
          hold_d  = HOLD_RELOAD;
          if (value_q != 16'hFFFF) begin
            value_d = value_q + 16'd1;
          end
        end
      end
      ST_MOVING: begin
        // A hit while already moving only retriggers the timer; it is not a new event.
        if (hit_q) begin
          hold_d = HOLD_RELOAD;
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else begin
          state_d = ST_STILL;
        end
      end
      default: begin
        state_d = ST_PRIME;
        hold_d  = '0;
      end
    endcase
    if (bus.clear_count) begin
      value_d = '0;
    end
  end

  assign bus.moving    = (state_q == ST_MOVING);
  assign bus.value     = value_q;
  assign bus.mag       = mag_q;
  assign bus.mag_valid = mag_valid_q;

endmodule
